alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational `alu` datapath between two requesters (fetch/branch unit and execute unit) using round-robin arbitration with valid/ready handshakes. Each accepted operation is registered, driven into an internally instanced `alu` for exactly one cycle, and its result, overflow and compare flags are captured into a per-requester response register. The block removes the datapath's hold-last-value behaviour on `overflow` and `comp_flag` by capturing only the fields relevant to each opcode.

## Interface
- No parameters. Word width is `WORD_SIZE` and opcodes `ADD`/`SUB`/`CMP` (5-bit), both from `top_macro.vh`.
- Clocking: one clock. Reset is asynchronous and active-high.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 2: bit i = requester i presents an operation.
- `req_ready` out 2: bit i = requester i's operation is accepted this cycle.
- `req_op0`, `req_op1` in 5 each: opcode for requester 0 and 1.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in `WORD_SIZE` each: signed operands.
- `rsp_valid` out 2: bit i = response for requester i is held.
- `rsp_ready` in 2: bit i = requester i consumes its response.
- `rsp_c0`, `rsp_c1` out `WORD_SIZE`: signed result.
- `rsp_ovf` out 2: overflow flag, one bit per requester.
- `rsp_flag0`, `rsp_flag1` out 2: compare flags; [0] = a==b, [1] = a>b (signed).
- `rsp_err` out 2: unsupported-opcode flag, one bit per requester.

## Operation
- Requester i is busy from its request handshake until its response handshake (`rsp_valid[i] && rsp_ready[i]`). Each requester has at most one outstanding operation.
- Eligibility: `eligible[i] = req_valid[i] && !busy[i]`. `busy` is registered state only, so a response consumed in cycle N permits a new accept from N+1.
- Arbitration: `last` pointer, 1 bit.
  - Both eligible: grant `!last`.
  - One eligible: grant it.
  - Neither eligible: no grant.
  - `last` updates to the granted index on every grant.
  - `req_ready` is one-hot or zero, and is combinational from `req_valid` and state.
- Issue register (valid, owner, op, a, b): loaded on grant. It drives the `alu` inputs in the following cycle and always clears after one cycle, so it never stalls. While empty, the `alu` sees `op` = 0 and operands = 0.
- Capture at the end of the issue cycle into response register `owner`:
  - `ADD`/`SUB`: `c` = `alu.c`; `ovf` = `alu.overflow`; `flag` = 00; `err` = 0.
  - `CMP`: `c` = 0; `ovf` = 0; `flag` = `alu.comp_flag`; `err` = 0.
  - Other opcodes: `c` = 0; `ovf` = 0; `flag` = 00; `err` = 1.
- Results are two's-complement and wrap to `WORD_SIZE`. Overflow follows the signed sign rule: ADD with operands of equal sign and a differing result sign; SUB with operands of opposite sign and a result sign differing from a.
- Response registers hold their values stable while `rsp_valid[i]=1 && rsp_ready[i]=0`.

## Timing
- Request handshake in cycle N. Issue in N+1. `rsp_valid[i]` rises at the edge ending N+1, so the response is visible in N+2. Latency is 2 cycles.
- Throughput is 1 accept per cycle across both requesters. A single requester issues at most once per 3 cycles when `rsp_ready` is held high.
- Reset, asynchronous and immediate:
  - `rsp_valid`, `rsp_c*`, `rsp_ovf`, `rsp_flag*`, `rsp_err`, issue valid and `busy` all go to 0.
  - `last` = 1, so requester 0 wins the first tie.
  - `req_ready` = 0 while `rst` is high.
  - Reset mid-operation discards any issued or held operation with no response.
- Simultaneous response handshake and new `req_valid` for the same requester in one cycle: no accept that cycle; the accept occurs the next cycle.
- A response handshake for requester 0 and a capture for requester 1 in the same cycle are independent and both complete.

## Test plan
- ADD basics: requester 0 sends `ADD` 5 + 7 with `rsp_ready` high. `req_ready[0]` asserts in cycle 0, and in cycle 2 `rsp_valid[0]` = 1, `rsp_c0` = 12, `rsp_ovf[0]` = 0, `rsp_err[0]` = 0.
- Overflow: with `WORD_SIZE` = 8, `ADD` 100 + 100 gives `rsp_c0` = -56 and `rsp_ovf[0]` = 1. `SUB` -100 - 100 gives `rsp_c0` = 56 and `rsp_ovf[0]` = 1.
- Compare and error: `CMP` 3, -2 gives `rsp_flag0` = 10, `rsp_c0` = 0, `rsp_ovf[0]` = 0. A following `ADD` 1 + 1 gives `rsp_flag0` = 00 (no stale flags). Opcode 31 gives `rsp_err[0]` = 1 and `rsp_c0` = 0.
- Round-robin: both requesters hold `req_valid` continuously with `rsp_ready` high. Grants alternate 0,1,0,1 (requester 0 first after reset), and each requester gets exactly one grant while busy.
- Backpressure: hold `rsp_ready[1]` = 0 for 10 cycles after a response. `rsp_c1` stays stable and `req_ready[1]` stays 0, while requester 0 continues to be served. After `rsp_ready[1]` pulses, requester 1 is accepted one cycle later.
- Reset mid-operation: assert `rst` the cycle after an accept. All outputs go to 0 immediately, no response appears afterwards, and the first post-reset tie is granted to requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational alu between two requesters,
// with a one-cycle issue stage and a held response register per requester.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef ADD
`define ADD 5'd1
`endif
`ifndef SUB
`define SUB 5'd2
`endif
`ifndef CMP
`define CMP 5'd3
`endif

module alu_arbiter (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [4:0]            req_op0,
  input  logic [4:0]            req_op1,
  input  logic [`WORD_SIZE-1:0] req_a0,
  input  logic [`WORD_SIZE-1:0] req_b0,
  input  logic [`WORD_SIZE-1:0] req_a1,
  input  logic [`WORD_SIZE-1:0] req_b1,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [`WORD_SIZE-1:0] rsp_c0,
  output logic [`WORD_SIZE-1:0] rsp_c1,
  output logic [1:0]            rsp_ovf,
  output logic [1:0]            rsp_flag0,
  output logic [1:0]            rsp_flag1,
  output logic [1:0]            rsp_err
);
  localparam int W = `WORD_SIZE;

  logic [1:0]   busy_q, busy_d, eligible, grant;
  logic         last_q, last_d;
  logic         iss_valid_q, iss_owner_q;
  logic [4:0]   iss_op_q;
  logic [W-1:0] iss_a_q, iss_b_q;
  logic [4:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_c;
  logic         alu_ovf;
  logic [1:0]   alu_flag;
  logic [W-1:0] cap_c;
  logic         cap_ovf, cap_err;
  logic [1:0]   cap_flag;
  logic [1:0]   rsp_valid_q, rsp_valid_d, rsp_ovf_q, rsp_ovf_d, rsp_err_q, rsp_err_d;
  logic [1:0]   rsp_flag0_q, rsp_flag0_d, rsp_flag1_q, rsp_flag1_d;
  logic [W-1:0] rsp_c0_q, rsp_c0_d, rsp_c1_q, rsp_c1_d;

  // busy is purely registered, so a response consumed this cycle frees the slot next cycle.
  assign eligible = req_valid & ~busy_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant = 2'b00;
    if (!rst) begin
      if (&eligible) grant = last_q ? 2'b01 : 2'b10;
      else           grant = eligible;
    end
  end

  assign req_ready = grant;
  assign last_d    = (|grant) ? grant[1] : last_q;
  assign busy_d    = (busy_q | grant) & ~(rsp_valid_q & rsp_ready);

  // NOTE: the issue payload is always qualified by iss_valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (|grant) begin
      iss_owner_q <= grant[1];
      iss_op_q    <= grant[1] ? req_op1 : req_op0;
      iss_a_q     <= grant[1] ? req_a1  : req_a0;
      iss_b_q     <= grant[1] ? req_b1  : req_b0;
    end
  end

  assign alu_op = iss_valid_q ? iss_op_q : 5'd0;
  assign alu_a  = iss_valid_q ? iss_a_q  : '0;
  assign alu_b  = iss_valid_q ? iss_b_q  : '0;

  alu u_alu (
    .op        (alu_op),
    .a         (alu_a),
    .b         (alu_b),
    .c         (alu_c),
    .overflow  (alu_ovf),
    .comp_flag (alu_flag)
  );

  // Keep only the fields meaningful for the opcode; the rest capture as zero.
  always_comb begin
    cap_c    = '0;
    cap_ovf  = 1'b0;
    cap_flag = 2'b00;
    cap_err  = 1'b0;
    case (iss_op_q)
      `ADD, `SUB: begin
        cap_c   = alu_c;
        cap_ovf = alu_ovf;
      end
      `CMP:    cap_flag = alu_flag;
      default: cap_err  = 1'b1;
    endcase
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_err_d   = rsp_err_q;
    rsp_c0_d    = rsp_c0_q;
    rsp_c1_d    = rsp_c1_q;
    rsp_flag0_d = rsp_flag0_q;
    rsp_flag1_d = rsp_flag1_q;
    if (iss_valid_q) begin
      rsp_valid_d[iss_owner_q] = 1'b1;
      rsp_ovf_d[iss_owner_q]   = cap_ovf;
      rsp_err_d[iss_owner_q]   = cap_err;
      if (iss_owner_q) begin
        rsp_c1_d    = cap_c;
        rsp_flag1_d = cap_flag;
      end else begin
        rsp_c0_d    = cap_c;
        rsp_flag0_d = cap_flag;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= 2'b00;
      last_q      <= 1'b1;
      iss_valid_q <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_ovf_q   <= 2'b00;
      rsp_err_q   <= 2'b00;
      rsp_c0_q    <= '0;
      rsp_c1_q    <= '0;
      rsp_flag0_q <= 2'b00;
      rsp_flag1_q <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      busy_q      <= busy_d;
      last_q      <= last_d;
      iss_valid_q <= |grant;
      rsp_valid_q <= rsp_valid_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_err_q   <= rsp_err_d;
      rsp_c0_q    <= rsp_c0_d;
      rsp_c1_q    <= rsp_c1_d;
      rsp_flag0_q <= rsp_flag0_d;
      rsp_flag1_q <= rsp_flag1_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_c0    = rsp_c0_q;
  assign rsp_c1    = rsp_c1_q;
  assign rsp_flag0 = rsp_flag0_q;
  assign rsp_flag1 = rsp_flag1_q;
endmodule

// Shared combinational datapath: wrapping add/sub with signed overflow, signed compare.
module alu (
  input  logic [4:0]            op,
  input  logic [`WORD_SIZE-1:0] a,
  input  logic [`WORD_SIZE-1:0] b,
  output logic [`WORD_SIZE-1:0] c,
  output logic                  overflow,
  output logic [1:0]            comp_flag
);
  localparam int W = `WORD_SIZE;

  logic [W-1:0] sum, diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    c         = '0;
    overflow  = 1'b0;
    comp_flag = 2'b00;
    case (op)
      `ADD: begin
        c        = sum;
        overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      `SUB: begin
        c        = diff;
        overflow = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      `CMP:    comp_flag = {$signed(a) > $signed(b), a == b};
      default: ;
    endcase
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a transaction-level model.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef ADD
`define ADD 5'd1
`endif
`ifndef SUB
`define SUB 5'd2
`endif
`ifndef CMP
`define CMP 5'd3
`endif

module tb_alu_arbiter;
  localparam int W = `WORD_SIZE;

  typedef struct {
    logic [4:0]          op;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic signed [W-1:0] c;
    logic                ovf;
    logic [1:0]          flag;
    logic                err;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [4:0]   req_op0, req_op1;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1, rsp_c0, rsp_c1;
  logic [1:0]   rsp_ovf, rsp_flag0, rsp_flag1, rsp_err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c0    (rsp_c0),
    .rsp_c1    (rsp_c1),
    .rsp_ovf   (rsp_ovf),
    .rsp_flag0 (rsp_flag0),
    .rsp_flag1 (rsp_flag1),
    .rsp_err   (rsp_err)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] op, input int a, input int b, input int c,
                              input logic ovf, input logic [1:0] flag, input logic err);
    vec_t v;
    v.op = op; v.a = W'(a); v.b = W'(b); v.c = W'(c);
    v.ovf = ovf; v.flag = flag; v.err = err;
    return v;
  endfunction

  // Reference: exact integer arithmetic, then wrap and range-test for overflow.
  function automatic vec_t ref_model(input logic [4:0] op, input logic signed [W-1:0] a,
                                     input logic signed [W-1:0] b);
    vec_t v;
    int   s;
    int   lo = -(1 << (W - 1));
    int   hi = (1 << (W - 1)) - 1;
    v.op = op; v.a = a; v.b = b; v.c = '0; v.ovf = 1'b0; v.flag = 2'b00; v.err = 1'b0;
    if (op == `ADD || op == `SUB) begin
      s     = (op == `ADD) ? int'(a) + int'(b) : int'(a) - int'(b);
      v.c   = W'(s);
      v.ovf = (s < lo) || (s > hi);
    end else if (op == `CMP) begin
      v.flag = {a > b, a == b};
    end else begin
      v.err = 1'b1;
    end
    return v;
  endfunction

  function automatic logic signed [W-1:0] c_of(input int r);
    return (r == 1) ? rsp_c1 : rsp_c0;
  endfunction

  function automatic logic [1:0] flag_of(input int r);
    return (r == 1) ? rsp_flag1 : rsp_flag0;
  endfunction

  task automatic set_req(input int r, input logic [4:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    if (r == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; end
    else        begin req_op1 = op; req_a1 = a; req_b1 = b; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One operation, checked cycle by cycle: accept, nothing in issue cycle, response next.
  task automatic run_vec(input int r, input vec_t v, input string tag);
    @(posedge clk); #1;
    set_req(r, v.op, v.a, v.b);
    req_valid[r] = 1'b1;
    @(negedge clk);
    check({tag, "_accept"}, req_ready[r], 1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, rsp_valid[r], 0);
    @(negedge clk);
    check({tag, "_valid"}, rsp_valid[r], 1);
    check({tag, "_c"}, c_of(r), v.c);
    check({tag, "_ovf"}, rsp_ovf[r], v.ovf);
    check({tag, "_flag"}, flag_of(r), v.flag);
    check({tag, "_err"}, rsp_err[r], v.err);
  endtask

  function automatic logic [4:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return `ADD;
      1:       return `SUB;
      2:       return `CMP;
      default: return 5'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[12];
    int   grants[$];
    int   cnt;
    exp_t q0[$], q1[$];
    logic last_g;
    logic [1:0] elig, exp_g;

    vecs[0]  = mk(`ADD,    5,    7,   12, 1'b0, 2'b00, 1'b0);
    vecs[1]  = mk(`ADD,  100,  100,  -56, 1'b1, 2'b00, 1'b0);
    vecs[2]  = mk(`SUB, -100,  100,   56, 1'b1, 2'b00, 1'b0);
    vecs[3]  = mk(`CMP,    3,   -2,    0, 1'b0, 2'b10, 1'b0);
    vecs[4]  = mk(`ADD,    1,    1,    2, 1'b0, 2'b00, 1'b0);
    vecs[5]  = mk(5'd31,   9,    4,    0, 1'b0, 2'b00, 1'b1);
    vecs[6]  = mk(`SUB,    5,    7,   -2, 1'b0, 2'b00, 1'b0);
    vecs[7]  = mk(`CMP,    4,    4,    0, 1'b0, 2'b01, 1'b0);
    vecs[8]  = mk(`ADD, -128,   -1,  127, 1'b1, 2'b00, 1'b0);
    vecs[9]  = mk(`SUB,  127,   -1, -128, 1'b1, 2'b00, 1'b0);
    vecs[10] = mk(`SUB,    0, -128, -128, 1'b1, 2'b00, 1'b0);
    vecs[11] = mk(`CMP,   -5,    3,    0, 1'b0, 2'b00, 1'b0);

    set_req(0, 5'd0, '0, '0);
    set_req(1, 5'd0, '0, '0);
    rst = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    #2;
    check("reset_req_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_c0", rsp_c0, 0);
    check("reset_rsp_err", rsp_err, 0);
    do_reset();

    // Directed table through both requesters.
    rsp_ready = 2'b11;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 12; i++)
        run_vec(r, vecs[i], $sformatf("vec%0d_r%0d", i, r));

    // Round-robin with both requesters saturating.
    do_reset();
    rsp_ready = 2'b11;
    @(posedge clk); #1;
    set_req(0, `ADD, 8'd1, 8'd2);
    set_req(1, `ADD, 8'd3, 8'd4);
    req_valid = 2'b11;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("rr_onehot_c%0d", k), $onehot0(req_ready), 1);
      if (req_ready != 2'b00) grants.push_back(req_ready[1] ? 1 : 0);
    end
    check("rr_grant_count", grants.size(), 8);
    foreach (grants[k]) check($sformatf("rr_grant%0d", k), grants[k], k % 2);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (4) @(negedge clk);

    // Backpressure on requester 1 while requester 0 keeps flowing.
    @(posedge clk); #1;
    rsp_ready = 2'b01;
    set_req(1, `ADD, 8'd20, 8'd22);
    req_valid = 2'b10;
    @(negedge clk);
    check("bp_accept1", req_ready, 2'b10);
    @(posedge clk); #1 req_valid = 2'b11;
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("bp_valid_c%0d", k), rsp_valid[1], 1);
      check($sformatf("bp_c1_c%0d", k), $signed(rsp_c1), 42);
      check($sformatf("bp_ready1_c%0d", k), req_ready[1], 0);
      if (req_ready[0]) cnt++;
    end
    check("bp_r0_served", cnt, 3);
    @(posedge clk); #1 rsp_ready = 2'b11;
    @(negedge clk);
    check("bp_pulse_no_accept", req_ready[1], 0);
    @(posedge clk); #1 rsp_ready = 2'b01;
    @(negedge clk);
    check("bp_accept_after_pulse", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (4) @(negedge clk);

    // Reset with a held response on requester 1 and an issue in flight on requester 0.
    @(posedge clk); #1;
    rsp_ready = 2'b01;
    set_req(1, `ADD, 8'd3, 8'd4);
    req_valid = 2'b10;
    @(negedge clk);
    check("rst_accept1", req_ready, 2'b10);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_held_c1", $signed(rsp_c1), 7);
    @(posedge clk); #1;
    set_req(0, `ADD, 8'd9, 8'd9);
    req_valid = 2'b01;
    @(negedge clk);
    check("rst_accept0", req_ready, 2'b01);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_now_rsp_valid", rsp_valid, 0);
    check("rst_now_c0", rsp_c0, 0);
    check("rst_now_c1", rsp_c1, 0);
    check("rst_now_ovf", rsp_ovf, 0);
    check("rst_now_flag0", rsp_flag0, 0);
    check("rst_now_flag1", rsp_flag1, 0);
    check("rst_now_err", rsp_err, 0);
    check("rst_now_req_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rst_no_rsp_c%0d", k), rsp_valid, 0);
    end
    @(posedge clk); #1 req_valid = 2'b11;
    @(negedge clk);
    check("rst_first_tie", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = 2'b00;

    // Randomized traffic against a transaction-level scoreboard.
    do_reset();
    last_g = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        req_valid[r] = ($urandom_range(0, 3) != 0);
        set_req(r, rand_op(), W'($urandom), W'($urandom));
        rsp_ready[r] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      elig  = {req_valid[1] && q1.size() == 0, req_valid[0] && q0.size() == 0};
      exp_g = (&elig) ? (last_g ? 2'b01 : 2'b10) : elig;
      check("rand_grant", req_ready, exp_g);
      for (int r = 0; r < 2; r++) begin
        exp_t e;
        logic has, due;
        has = (r == 0) ? (q0.size() != 0) : (q1.size() != 0);
        if (!has) begin
          check("rand_spurious_rsp", rsp_valid[r], 0);
        end else begin
          e   = (r == 0) ? q0[0] : q1[0];
          due = (n >= e.acc + 2);
          check("rand_rsp_valid", rsp_valid[r], due);
          if (due) begin
            check("rand_c", c_of(r), e.v.c);
            check("rand_ovf", rsp_ovf[r], e.v.ovf);
            check("rand_flag", flag_of(r), e.v.flag);
            check("rand_err", rsp_err[r], e.v.err);
            if (rsp_ready[r]) begin
              if (r == 0) void'(q0.pop_front());
              else        void'(q1.pop_front());
            end
          end
        end
      end
      if (exp_g[0]) q0.push_back('{ref_model(req_op0, req_a0, req_b0), n});
      if (exp_g[1]) q1.push_back('{ref_model(req_op1, req_a1, req_b1), n});
      if (exp_g != 2'b00) last_g = exp_g[1];
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
